// File: rtl/bus_cycle_unit_pkg.sv
// Shared codes for the 6809 bus sequencer: address-source and data-bus selects, FSM states.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package bus_cycle_unit_pkg;

    // Address-source codes, shared with the control unit; 8..15 are illegal
    localparam logic [3:0] AB_NONE   = 4'd0;
    localparam logic [3:0] AB_PC     = 4'd1;
    localparam logic [3:0] AB_AR     = 4'd2;
    localparam logic [3:0] AB_SP     = 4'd3;
    localparam logic [3:0] AB_US     = 4'd4;
    localparam logic [3:0] AB_X      = 4'd5;
    localparam logic [3:0] AB_Y      = 4'd6;
    localparam logic [3:0] AB_DP_ARL = 4'd7;

    // Data-bus codes relevant to the memory interface
    localparam logic [4:0] DB_NONE = 5'd0;
    localparam logic [4:0] DB_MEM  = 5'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } bus_state_t;

endpackage

// File: rtl/bus_cycle_unit_addr_mux.sv
// Address former: selects the 16-bit bus address from ab_sel and flags non-AB codes.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
module bus_cycle_unit_addr_mux
    import bus_cycle_unit_pkg::*;
(
    input  logic [3:0]  ab_sel,
    input  logic [15:0] PC,
    input  logic [15:0] SP,
    input  logic [15:0] US,
    input  logic [15:0] X,
    input  logic [15:0] Y,
    input  logic [15:0] AR,
    input  logic [7:0]  DP,
    output logic [15:0] addr,
    output logic        illegal
);

    // Decode the source; AB_NONE yields a zero address and is not illegal
    always_comb begin
        addr    = 16'h0000;
        illegal = 1'b0;
        case (ab_sel)
            AB_NONE:   addr = 16'h0000;
            AB_PC:     addr = PC;
            AB_AR:     addr = AR;
            AB_SP:     addr = SP;
            AB_US:     addr = US;
            AB_X:      addr = X;
            AB_Y:      addr = Y;
            AB_DP_ARL: addr = {DP, AR[7:0]};
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/bus_cycle_unit.sv
// Memory bus sequencer: one req/ack transaction per start, with wait states and timeout abort.
// Latency: start cycle + (waits+1) REQ cycles, results pulse in the following DONE cycle.
// Backpressure: stall held high in the start cycle and all REQ cycles; mem_ack paces completion.
module bus_cycle_unit
    import bus_cycle_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 15,
    parameter logic [7:0]  ERR_DATA = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  ab_sel,
    input  logic [4:0]  db_sel,
    input  logic        wr,
    input  logic [7:0]  wdata,
    input  logic [3:0]  inc_req,
    input  logic [15:0] PC,
    input  logic [15:0] SP,
    input  logic [15:0] US,
    input  logic [15:0] X,
    input  logic [15:0] Y,
    input  logic [15:0] AR,
    input  logic [7:0]  DP,
    output logic        stall,
    output logic [7:0]  rdata,
    output logic        rdata_valid,
    output logic [3:0]  inc_out,
    output logic        bus_err,
    output logic [15:0] mem_addr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    bus_state_t  state, state_nxt;
    logic [15:0] addr;
    logic        illegal;
    logic        access;
    logic        start_ok;
    logic        start_bad;
    logic        can_start;
    logic        timeout_hit;
    logic [7:0]  wait_cnt;
    logic [3:0]  inc_q;
    logic        err_q;

    bus_cycle_unit_addr_mux u_addr_mux (
        .ab_sel  (ab_sel),
        .PC      (PC),
        .SP      (SP),
        .US      (US),
        .X       (X),
        .Y       (Y),
        .AR      (AR),
        .DP      (DP),
        .addr    (addr),
        .illegal (illegal)
    );

    // A write request wins over a memory read on the same cycle (mem_we follows wr)
    assign access      = (ab_sel != AB_NONE) && ((db_sel == DB_MEM) || wr);
    assign can_start   = (state != ST_REQ);
    assign start_ok    = can_start && access && !illegal;
    assign start_bad   = can_start && access && illegal;
    assign timeout_hit = (wait_cnt == TIMEOUT_CNT);

    // State register; reset drops mem_req at once because it is decoded from state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state plus stall/req and the DONE-cycle result pulses
    always_comb begin
        state_nxt   = state;
        stall       = 1'b0;
        mem_req     = 1'b0;
        rdata_valid = 1'b0;
        bus_err     = 1'b0;
        inc_out     = 4'h0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (state == ST_DONE) begin
                    rdata_valid = !mem_we;
                    bus_err     = err_q;
                    // Post-increment only for accesses that really completed
                    inc_out     = err_q ? 4'h0 : inc_q;
                end
                if (start_ok) begin
                    state_nxt = ST_REQ;
                    stall     = 1'b1;
                end else if (start_bad) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                mem_req = 1'b1;
                stall   = 1'b1;
                if (mem_ack || timeout_hit) state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Transaction latches, wait counter and read-data holding register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr  <= 16'h0000;
            mem_we    <= 1'b0;
            mem_wdata <= 8'h00;
            inc_q     <= 4'h0;
            err_q     <= 1'b0;
            wait_cnt  <= 8'h00;
            rdata     <= 8'h00;
        end else if (start_ok || start_bad) begin
            mem_we   <= wr;
            err_q    <= illegal;
            wait_cnt <= 8'h00;
            if (start_ok) begin
                mem_addr  <= addr;
                mem_wdata <= wdata;
                inc_q     <= inc_req;
            end else begin
                inc_q <= 4'h0;
                if (!wr) rdata <= ERR_DATA;
            end
        end else if (state == ST_REQ) begin
            if (mem_ack) begin
                // Ack wins over a coincident timeout
                err_q <= 1'b0;
                if (!mem_we) rdata <= mem_rdata;
            end else if (timeout_hit) begin
                err_q <= 1'b1;
                if (!mem_we) rdata <= ERR_DATA;
            end else if (wait_cnt != 8'hFF) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_bus_cycle_unit.sv
module tb_bus_cycle_unit;
    import bus_cycle_unit_pkg::*;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  ab_sel;
    logic [4:0]  db_sel;
    logic        wr;
    logic [7:0]  wdata;
    logic [3:0]  inc_req;
    logic [15:0] PC, SP, US, X, Y, AR;
    logic [7:0]  DP;
    logic        stall;
    logic [7:0]  rdata;
    logic        rdata_valid;
    logic [3:0]  inc_out;
    logic        bus_err;
    logic [15:0] mem_addr;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  exp_rdata;

    always #5 clk = ~clk;

    bus_cycle_unit #(.TIMEOUT(TO), .ERR_DATA(8'hFF)) dut (
        .clk(clk), .reset(reset), .ab_sel(ab_sel), .db_sel(db_sel), .wr(wr),
        .wdata(wdata), .inc_req(inc_req), .PC(PC), .SP(SP), .US(US), .X(X),
        .Y(Y), .AR(AR), .DP(DP), .stall(stall), .rdata(rdata),
        .rdata_valid(rdata_valid), .inc_out(inc_out), .bus_err(bus_err),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Address the bus should present for a select code; -1 for a non-source code
    function automatic int ref_addr(input logic [3:0] ab);
        case (ab)
            AB_PC:     return int'(PC);
            AB_AR:     return int'(AR);
            AB_SP:     return int'(SP);
            AB_US:     return int'(US);
            AB_X:      return int'(X);
            AB_Y:      return int'(Y);
            AB_DP_ARL: return int'(DP) * 256 + int'(AR) % 256;
            default:   return -1;
        endcase
    endfunction

    task automatic scramble();
        PC = 16'($urandom); SP = 16'($urandom); US = 16'($urandom);
        X  = 16'($urandom); Y  = 16'($urandom); AR = 16'($urandom);
        DP = 8'($urandom);  wdata = 8'($urandom); inc_req = 4'($urandom);
    endtask

    // One access: start cycle, REQ phase with memory acking after 'waits' idle cycles,
    // ending sampled inside the DONE cycle. b2b starts from an ongoing DONE cycle.
    task automatic run_txn(input logic [3:0] ab, input logic w, input logic [7:0] wd,
                           input logic [3:0] inc, input int waits, input logic [7:0] rd_data,
                           input logic b2b);
        int   ea;
        int   k;
        int   exp_req;
        logic legal;
        logic tmo;
        logic is_rd;
        if (!b2b) @(negedge clk);
        ab_sel    = ab;
        wr        = w;
        db_sel    = w ? 5'($urandom_range(0, 31)) : DB_MEM;
        wdata     = wd;
        inc_req   = inc;
        mem_ack   = 1'b0;
        mem_rdata = rd_data;
        ea    = ref_addr(ab);
        legal = (ea >= 0);
        is_rd = !w;
        tmo   = legal && (waits > TO);
        #1;
        check("start_stall", stall, legal);
        check("start_no_req", mem_req, 0);
        @(negedge clk);
        ab_sel = AB_NONE; wr = 1'b0; db_sel = DB_NONE;
        scramble();
        if (legal) begin
            k = 0;
            while (k < 300) begin
                mem_ack = (k == waits);
                #1;
                if (!mem_req) break;
                check("req_addr", mem_addr, ea);
                check("req_we", mem_we, w);
                if (w) check("req_wdata", mem_wdata, wd);
                check("req_stall", stall, 1);
                check("req_no_inc", inc_out, 0);
                k++;
                @(negedge clk);
                scramble();
            end
            mem_ack = 1'b0;
            exp_req = tmo ? TO + 1 : waits + 1;
            check("req_cycles", k, exp_req);
        end else begin
            #1;
        end
        if (is_rd) exp_rdata = (!legal || tmo) ? 8'hFF : rd_data;
        check("done_no_req", mem_req, 0);
        check("done_stall", stall, 0);
        check("done_bus_err", bus_err, !legal || tmo);
        check("done_rvalid", rdata_valid, is_rd);
        check("done_rdata", rdata, exp_rdata);
        check("done_inc", inc_out, (legal && !tmo) ? inc : 4'h0);
    endtask

    task automatic idle_check();
        @(negedge clk);
        #1;
        check("idle_req", mem_req, 0);
        check("idle_err", bus_err, 0);
        check("idle_rvalid", rdata_valid, 0);
        check("idle_inc", inc_out, 0);
        check("idle_rdata", rdata, exp_rdata);
    endtask

    initial begin
        reset = 1'b0; ab_sel = AB_NONE; db_sel = DB_NONE; wr = 1'b0;
        mem_ack = 1'b0; mem_rdata = 8'h00;
        scramble();
        exp_rdata = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req", mem_req, 0);
        check("rst_stall", stall, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rvalid", rdata_valid, 0);
        check("rst_err", bus_err, 0);
        check("rst_inc", inc_out, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_we", mem_we, 0);
        check("rst_wdata", mem_wdata, 0);
        @(negedge clk);
        reset = 1'b1;

        // Zero-wait read from PC
        PC = 16'h1234;
        run_txn(AB_PC, 1'b0, 8'h00, 4'h0, 0, 8'h5A, 1'b0);
        idle_check();
        // Direct-page write with three wait states
        DP = 8'h20; AR = 16'h9945;
        run_txn(AB_DP_ARL, 1'b1, 8'hC3, 4'h0, 3, 8'h00, 1'b0);
        idle_check();
        // Timeout, then ack exactly on the last allowed cycle
        run_txn(AB_SP, 1'b0, 8'h00, 4'h0, 1000, 8'h77, 1'b0);
        idle_check();
        run_txn(AB_SP, 1'b0, 8'h00, 4'h0, TO, 8'h3C, 1'b0);
        idle_check();
        // Post-increment with a back-to-back follow-on access
        PC = 16'h00FF;
        run_txn(AB_PC, 1'b0, 8'h00, AB_PC, 2, 8'h11, 1'b0);
        X = 16'hBEEF;
        run_txn(AB_X, 1'b0, 8'h00, AB_X, 0, 8'h22, 1'b1);
        idle_check();
        // Illegal source code
        run_txn(4'hE, 1'b0, 8'h00, AB_PC, 0, 8'h00, 1'b0);
        idle_check();

        // Reset in the middle of a REQ phase
        @(negedge clk);
        PC = 16'h4000; ab_sel = AB_PC; db_sel = DB_MEM; wr = 1'b0; inc_req = AB_PC;
        @(negedge clk);
        ab_sel = AB_NONE; db_sel = DB_NONE; inc_req = 4'h0;
        repeat (2) @(negedge clk);
        #1;
        check("pre_rst_req", mem_req, 1);
        reset = 1'b0;
        #1;
        exp_rdata = 8'h00;
        check("midrst_req", mem_req, 0);
        check("midrst_stall", stall, 0);
        check("midrst_err", bus_err, 0);
        check("midrst_rvalid", rdata_valid, 0);
        check("midrst_inc", inc_out, 0);
        check("midrst_rdata", rdata, 0);
        @(negedge clk);
        reset = 1'b1;
        idle_check();

        // Randomized accesses
        for (int i = 0; i < 120; i++) begin
            logic [3:0] ab;
            logic       b2b;
            scramble();
            ab  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15))
                                              : 4'($urandom_range(1, 7));
            b2b = (i > 0) && ($urandom_range(0, 2) == 0);
            run_txn(ab, 1'($urandom), 8'($urandom), 4'($urandom), $urandom_range(0, 20),
                    8'($urandom), b2b);
        end
        idle_check();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
